maxpool_ctrl: RTL and testbench
===============================

# maxpool_ctrl

Sequencer for the 2x2 max-pooling datapath after the second-stage convolution. Scans a feature map held in a synchronous single-port buffer, fetches each non-overlapping 2x2 window, drives the four operands and enable of the maxpool datapath, and writes each pooled result to the output buffer through a ready/valid write port. One start pulse processes one full feature map.

## Interface
- IMG_W, 24, input map width in pixels (even, >= 2)
- IMG_H, 24, input map height in pixels (even, >= 2)
- DW, 16, signed pixel width
- AW, 10, address width for both buffers (2^AW >= IMG_W*IMG_H)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to pool a map; ignored while busy
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  AW  input-buffer read address
- rd_data  in  DW  signed read data, valid exactly one cycle after rd_en
- in1, in2, in3, in4  out  DW each  signed window operands to maxpool datapath
- pool_en  out  1  maxpool datapath enable
- pool_result  in  DW  signed maxpool datapath output
- wr_en  out  1  output-buffer write valid
- wr_addr  out  AW  output-buffer address
- wr_data  out  DW  signed pooled value
- wr_ready  in  1  output buffer accepts write when high with wr_en
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after last write accepted

## Operation
- States: IDLE, RD, CAP, POOL, WR, DONE.
- IDLE: start=1 -> RD; clears ox, oy, rd_cnt.
- Window (ox, oy), ox in 0..IMG_W/2-1, oy in 0..IMG_H/2-1, row-major (ox fastest). Base b = 2*oy*IMG_W + 2*ox.
- RD: 4 cycles, rd_en=1, rd_addr = b, b+1, b+IMG_W, b+IMG_W+1 for rd_cnt 0..3. Data returning one cycle later loads in1, in2, in3, in4 respectively. After rd_cnt=3 -> CAP.
- CAP: 1 cycle; in4 loaded at its end. -> POOL.
- POOL: 2 cycles, pool_en=1 (datapath needs two enabled edges: pair compare, then final compare). -> WR.
- WR: wr_en=1, wr_addr = oy*(IMG_W/2)+ox, wr_data = pool_result registered on entry to WR (optionally clamped, see Configuration). Hold all three stable until wr_ready=1. On accept: last window -> DONE; else advance ox (wrap to 0, increment oy) -> RD.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- in1..in4 hold last values outside RD/CAP; pool_result is ignored outside WR entry; the datapath's own finished flag is not used.
- All arithmetic on addresses unsigned AW bits; pixel values pass through unmodified signed DW bits.

## Timing
- Reset values: rd_en=0, rd_addr=0, in1..in4=0, pool_en=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; state IDLE.
- start seen in cycle t -> first rd_en at t+1, busy=1 from t+1.
- Per window, wr_ready tied high: 8 cycles (4 RD, 1 CAP, 2 POOL, 1 WR). Map of N=(IMG_W/2)*(IMG_H/2) windows: last write accepted at t+8N, done at t+8N+1.
- wr_ready low stalls in WR only; rd_en and pool_en stay 0 during stall.
- start during busy or DONE: ignored, no queuing. start in same cycle as done: ignored.
- rst_n low at any time, including mid-window or mid-stall: immediate return to reset values; partial map discarded, no resume.

## Configuration
- MAXPOOL_CTRL_RELU_EN defined: wr_data = 0 when pool_result is negative, else pool_result (fused ReLU after pooling).
- Undefined: wr_data = pool_result unchanged, negatives written as-is.

## Test plan
- 4x4 map (IMG_W=IMG_H=4) values 0..15 row-major, wr_ready=1, datapath model with 2-enable latency -> writes (0,5),(1,7),(2,13),(3,15); done exactly 33 cycles after start.
- Window {-7,-3,-9,-12}, MAXPOOL_CTRL_RELU_EN undefined -> wr_data=-3; defined -> wr_data=0.
- wr_ready low 5 cycles on second write -> wr_en, wr_addr=1, wr_data stable throughout; no rd_en or pool_en; done delayed by 5 cycles.
- start pulsed again at cycle 10 of a run -> ignored; exactly N writes, one done pulse.
- rst_n low during POOL of window 2 -> all outputs 0 next edge; new start rescans from rd_addr=0.
- Default 24x24 map -> 144 writes, addresses 0..143 in order, rd_addr pattern b,b+1,b+24,b+25 each window.

Source files
------------

// File: rtl/maxpool_ctrl_if.sv
// Read, datapath and write ports between the 2x2 maxpool sequencer and its
// input buffer, maxpool datapath and output buffer.
interface maxpool_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] in1;
    logic signed [DW-1:0] in2;
    logic signed [DW-1:0] in3;
    logic signed [DW-1:0] in4;
    logic                 pool_en;
    logic signed [DW-1:0] pool_result;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 wr_ready;

    modport master (
        output rd_en, rd_addr, in1, in2, in3, in4, pool_en, wr_en, wr_addr, wr_data,
        input  rd_data, pool_result, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, in1, in2, in3, in4, pool_en, wr_en, wr_addr, wr_data,
        output rd_data, pool_result, wr_ready
    );
endinterface

// File: rtl/maxpool_ctrl.sv
// 2x2 max-pooling sequencer: scans the input map window by window, feeds the
// maxpool datapath and writes one pooled value per window.
// Optional fused ReLU on the written value: define MAXPOOL_CTRL_RELU_EN.
module maxpool_ctrl #(
    parameter int IMG_W = 24,
    parameter int IMG_H = 24,
    parameter int DW    = 16,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    maxpool_ctrl_if.master  bus,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {IDLE, RD, CAP, POOL, WR, DONE} state_t;

    localparam logic [AW-1:0] OX_LAST = AW'(IMG_W / 2 - 1);
    localparam logic [AW-1:0] OY_LAST = AW'(IMG_H / 2 - 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        ox_q, ox_d, oy_q, oy_d;
    logic [1:0]           rd_cnt_q, rd_cnt_d;
    logic                 pend_q, pend_d;
    logic [1:0]           pend_idx_q, pend_idx_d;
    logic                 pool_ph_q, pool_ph_d;
    logic                 rd_en_q, rd_en_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic signed [DW-1:0] in1_q, in1_d, in2_q, in2_d, in3_q, in3_d, in4_q, in4_d;
    logic                 pool_en_q, pool_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic signed [DW-1:0] wr_data_d, wr_data_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Input-buffer address of pixel k (0..3) of window (x, y).
    function automatic logic [AW-1:0] rd_addr_of(input logic [AW-1:0] x,
                                                  input logic [AW-1:0] y,
                                                  input logic [1:0]    k);
        logic [AW-1:0] a;
        a = (AW'(2 * IMG_W) * y) + (x << 1);
        if (k[1]) a = a + AW'(IMG_W);
        if (k[0]) a = a + AW'(1);
        return a;
    endfunction

    // Next-state and next-output computation for the window sequencer.
    always_comb begin
        state_d    = state_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        rd_cnt_d   = rd_cnt_q;
        pool_ph_d  = pool_ph_q;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        in3_d      = in3_q;
        in4_d      = in4_q;
        pool_en_d  = pool_en_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        // A read issued this cycle returns data next cycle; remember its slot.
        pend_d     = rd_en_q;
        pend_idx_d = rd_cnt_q;

        if (pend_q) begin
            case (pend_idx_q)
                2'd0:    in1_d = bus.rd_data;
                2'd1:    in2_d = bus.rd_data;
                2'd2:    in3_d = bus.rd_data;
                default: in4_d = bus.rd_data;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD;
                    ox_d      = '0;
                    oy_d      = '0;
                    rd_cnt_d  = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            RD: begin
                if (rd_cnt_q == 2'd3) begin
                    state_d = CAP;
                    rd_en_d = 1'b0;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 2'd1;
                    rd_addr_d = rd_addr_of(ox_q, oy_q, rd_cnt_q + 2'd1);
                end
            end
            CAP: begin
                state_d   = POOL;
                pool_en_d = 1'b1;
                pool_ph_d = 1'b0;
            end
            POOL: begin
                if (!pool_ph_q) begin
                    pool_ph_d = 1'b1;
                end else begin
                    state_d   = WR;
                    pool_en_d = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = (AW'(IMG_W / 2) * oy_q) + ox_q;
`ifdef MAXPOOL_CTRL_RELU_EN
                    wr_data_d = bus.pool_result[DW-1] ? '0 : bus.pool_result;
`else
                    wr_data_d = bus.pool_result;
`endif
                end
            end
            WR: begin
                if (bus.wr_ready) begin
                    wr_en_d = 1'b0;
                    if (ox_q == OX_LAST && oy_q == OY_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (ox_q == OX_LAST) begin
                            ox_d = '0;
                            oy_d = oy_q + AW'(1);
                        end else begin
                            ox_d = ox_q + AW'(1);
                        end
                        state_d   = RD;
                        rd_cnt_d  = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_addr_of(ox_d, oy_d, 2'd0);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any partial map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            rd_cnt_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            pool_ph_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            in3_q      <= '0;
            in4_q      <= '0;
            pool_en_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            rd_cnt_q   <= rd_cnt_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pool_ph_q  <= pool_ph_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            in3_q      <= in3_d;
            in4_q      <= in4_d;
            pool_en_q  <= pool_en_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.in1     = in1_q;
    assign bus.in2     = in2_q;
    assign bus.in3     = in3_q;
    assign bus.in4     = in4_q;
    assign bus.pool_en = pool_en_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Randomized bench for maxpool_ctrl on a non-square map with buffer and
// datapath models, a window-level scoreboard and cycle-accurate latency checks.
module tb_maxpool_ctrl;
    localparam int W  = 6;
    localparam int H  = 4;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int N  = (W / 2) * (H / 2);

    typedef struct {
        int addr;
        int data;
        int p0, p1, p2, p3;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    maxpool_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    maxpool_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mem [W*H];
    int exp_rd[$];
    win_t exp_wr[$];
    int start_cyc = 0;
    bit first_rd = 1'b0;
    bit mon_on = 1'b0;
    int wr_count = 0, done_cnt = 0, stall_cnt = 0, pool_cnt = 0;
    int ready_mode = 0;
    int stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Synchronous input buffer: data valid the cycle after rd_en.
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= DW'(mem[bus.rd_addr]);

    // Maxpool datapath: pair compare on first enabled edge, final compare follows.
    logic signed [DW-1:0] pa = '0, pb = '0;
    always @(posedge clk) if (bus.pool_en) begin
        pa <= (bus.in1 > bus.in2) ? bus.in1 : bus.in2;
        pb <= (bus.in3 > bus.in4) ? bus.in3 : bus.in4;
    end
    assign bus.pool_result = (pa > pb) ? pa : pb;

    // Output-buffer ready behaviour.
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: if (bus.wr_en && wr_count == 1 && stall_left > 0) begin
                       bus.wr_ready = 1'b0;
                       stall_left--;
                   end else bus.wr_ready = 1'b1;
                2: bus.wr_ready = ($urandom_range(0, 2) != 0);
                default: bus.wr_ready = 1'b1;
            endcase
        end
    end

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
`ifdef MAXPOOL_CTRL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic prep_map(input bit neg_win);
        logic signed [DW-1:0] r;
        win_t w;
        int b;
        for (int i = 0; i < W*H; i++) begin
            r = DW'($urandom);
            mem[i] = int'(r);
        end
        if (neg_win) begin
            mem[0] = -7; mem[1] = -3; mem[W] = -9; mem[W+1] = -12;
        end
        exp_rd.delete();
        exp_wr.delete();
        for (int oy = 0; oy < H/2; oy++)
            for (int ox = 0; ox < W/2; ox++) begin
                b = 2*oy*W + 2*ox;
                exp_rd.push_back(b);
                exp_rd.push_back(b + 1);
                exp_rd.push_back(b + W);
                exp_rd.push_back(b + W + 1);
                w.addr = oy*(W/2) + ox;
                w.p0 = mem[b]; w.p1 = mem[b+1]; w.p2 = mem[b+W]; w.p3 = mem[b+W+1];
                w.data = max4(w.p0, w.p1, w.p2, w.p3);
                exp_wr.push_back(w);
            end
    endtask

    // Protocol monitor, sampled mid-cycle.
    always @(negedge clk) if (rst_n === 1'b1 && mon_on) begin
        if (bus.rd_en) begin
            if (first_rd) begin
                chk("rd_latency", cyc - start_cyc, 1);
                chk("busy_start", int'(busy), 1);
                first_rd = 1'b0;
            end
            if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_addr", int'(bus.rd_addr), exp_rd.pop_front());
        end
        if (bus.pool_en) begin
            pool_cnt++;
            if (exp_wr.size() == 0) chk("pool_extra", 1, 0);
            else begin
                chk("in1", int'(bus.in1), exp_wr[0].p0);
                chk("in2", int'(bus.in2), exp_wr[0].p1);
                chk("in3", int'(bus.in3), exp_wr[0].p2);
                chk("in4", int'(bus.in4), exp_wr[0].p3);
            end
        end
        if (bus.wr_en) begin
            chk("busy_wr", int'(busy), 1);
            if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
            else if (!bus.wr_ready) begin
                stall_cnt++;
                chk("stall_rd_en", int'(bus.rd_en), 0);
                chk("stall_pool_en", int'(bus.pool_en), 0);
                chk("stall_addr", int'(bus.wr_addr), exp_wr[0].addr);
                chk("stall_data", int'(bus.wr_data), exp_wr[0].data);
            end else begin
                chk("wr_addr", int'(bus.wr_addr), exp_wr[0].addr);
                chk("wr_data", int'(bus.wr_data), exp_wr[0].data);
                chk("pool_cycles", pool_cnt, 2);
                pool_cnt = 0;
                void'(exp_wr.pop_front());
                wr_count++;
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_latency", cyc - start_cyc, 8*N + 1 + stall_cnt);
            chk("busy_done", int'(busy), 0);
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_rd_en"},   int'(bus.rd_en), 0);
        chk({pfx, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({pfx, "_in1"},     int'(bus.in1), 0);
        chk({pfx, "_in2"},     int'(bus.in2), 0);
        chk({pfx, "_in3"},     int'(bus.in3), 0);
        chk({pfx, "_in4"},     int'(bus.in4), 0);
        chk({pfx, "_pool_en"}, int'(bus.pool_en), 0);
        chk({pfx, "_wr_en"},   int'(bus.wr_en), 0);
        chk({pfx, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({pfx, "_wr_data"}, int'(bus.wr_data), 0);
        chk({pfx, "_busy"},    int'(busy), 0);
        chk({pfx, "_done"},    int'(done), 0);
    endtask

    task automatic kick(input int mode, input bit neg_win);
        prep_map(neg_win);
        ready_mode = mode;
        stall_left = 5;
        stall_cnt = 0; wr_count = 0; done_cnt = 0; pool_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        first_rd = 1'b1;
    endtask

    task automatic run_map(input int mode, input bit repulse, input bit neg_win);
        bit got_done;
        kick(mode, neg_win);
        got_done = 1'b0;
        for (int i = 0; i < 8*N + 200 && !got_done; i++) begin
            @(posedge clk); #1;
            start = repulse && (cyc == start_cyc + 10);
            if (done) got_done = 1'b1;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        start = 1'b1;                 // coincides with done: must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        if (mode == 1) chk("stall_len", stall_cnt, 5);
        chk("wr_count", wr_count, N);
        chk("done_count", done_cnt, 1);
        chk("rd_left", exp_rd.size(), 0);
        chk("busy_idle", int'(busy), 0);
        ready_mode = 0;
    endtask

    task automatic run_abort();
        bit hit;
        kick(0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 8*N && !hit; i++) begin
            @(posedge clk); #1;
            if (wr_count == 2 && bus.pool_en) hit = 1'b1;
        end
        if (!hit) chk("abort_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        exp_rd.delete();
        exp_wr.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        mon_on = 1'b1;
        run_map(0, 1'b0, 1'b1);   // clean run, all-negative first window
        run_map(1, 1'b0, 1'b0);   // 5-cycle stall on the second write
        run_map(0, 1'b1, 1'b0);   // start re-pulsed mid-run
        run_map(2, 1'b0, 1'b0);   // random back-pressure
        run_abort();              // reset during POOL of window 2
        run_map(0, 1'b0, 1'b0);   // fresh scan from address 0
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
